// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester and display RAM signal bundle for vram_arbiter
interface vram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              ren_req;
  logic [ADDR_W-1:0] ren_addr;
  logic              ren_valid;
  logic [DATA_W-1:0] ren_dat;
  logic              fill_start;
  logic [DATA_W-1:0] fill_char;
  logic              fill_busy;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdat;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdat;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdat;
  logic [DATA_W-1:0] mem_rdat;

  // Requesters and the RAM model sit on this side.
  modport master (
    output ren_req, ren_addr, fill_start, fill_char,
    output cpu_req, cpu_we, cpu_addr, cpu_wdat, mem_rdat,
    input  ren_valid, ren_dat, fill_busy, cpu_ack, cpu_rdat,
    input  mem_en, mem_we, mem_addr, mem_wdat
  );

  // The arbiter sits on this side.
  modport slave (
    input  ren_req, ren_addr, fill_start, fill_char,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdat, mem_rdat,
    output ren_valid, ren_dat, fill_busy, cpu_ack, cpu_rdat,
    output mem_en, mem_we, mem_addr, mem_wdat
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display RAM arbiter: renderer > fill engine > CPU
module vram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int COLS   = 40,
  parameter int ROWS   = 30
) (
  input logic         clk,
  input logic         clr,
  vram_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  typedef enum logic {FILL_IDLE, FILL_RUN} fill_state_t;
  typedef enum logic {CPU_IDLE, CPU_ACK} cpu_state_t;

  fill_state_t       fill_state_q, fill_state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] char_q, char_d;
  cpu_state_t        cpu_state_q, cpu_state_d;
  logic              cpu_we_q, cpu_we_d;
  logic              ren_valid_q, ren_valid_d;

  logic ren_gnt;
  logic fill_wr;
  logic cpu_gnt;

  // Grant decision; nothing reaches the RAM while clr is asserted.
  always_comb begin
    ren_gnt = !clr && bus.ren_req;
    fill_wr = !clr && (fill_state_q == FILL_RUN) && !bus.ren_req;
    // A fill_start sampled this cycle takes the slot from the CPU, and the
    // CPU cannot be regranted in its own ack cycle.
    cpu_gnt = !clr && bus.cpu_req && !bus.ren_req &&
              (fill_state_q == FILL_IDLE) && !bus.fill_start &&
              (cpu_state_q == CPU_IDLE);
  end

  // Fill engine next state: a renderer cycle holds ptr and defers the write.
  always_comb begin
    fill_state_d = fill_state_q;
    ptr_d        = ptr_q;
    char_d       = char_q;
    case (fill_state_q)
      FILL_IDLE: begin
        if (bus.fill_start) begin
          fill_state_d = FILL_RUN;
          ptr_d        = '0;
          char_d       = bus.fill_char;
        end
      end
      FILL_RUN: begin
        if (fill_wr) begin
          if (ptr_q == LAST_ADDR) begin
            fill_state_d = FILL_IDLE;
            ptr_d        = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: fill_state_d = FILL_IDLE;
    endcase
  end

  // CPU handshake next state: grant cycle, then exactly one ack cycle.
  always_comb begin
    cpu_state_d = cpu_state_q;
    cpu_we_d    = cpu_we_q;
    ren_valid_d = ren_gnt;
    case (cpu_state_q)
      CPU_IDLE: begin
        if (cpu_gnt) begin
          cpu_state_d = CPU_ACK;
          cpu_we_d    = bus.cpu_we;
        end
      end
      CPU_ACK:  cpu_state_d = CPU_IDLE;
      default:  cpu_state_d = CPU_IDLE;
    endcase
  end

  // State registers with synchronous reset; clr mid-fill simply abandons ptr.
  always_ff @(posedge clk) begin
    if (clr) begin
      fill_state_q <= FILL_IDLE;
      ptr_q        <= '0;
      char_q       <= '0;
      cpu_state_q  <= CPU_IDLE;
      cpu_we_q     <= 1'b0;
      ren_valid_q  <= 1'b0;
    end else begin
      fill_state_q <= fill_state_d;
      ptr_q        <= ptr_d;
      char_q       <= char_d;
      cpu_state_q  <= cpu_state_d;
      cpu_we_q     <= cpu_we_d;
      ren_valid_q  <= ren_valid_d;
    end
  end

  // RAM pin mux of the granted requester; all zero when nobody is granted.
  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdat = '0;
    if (ren_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.ren_addr;
    end else if (fill_wr) begin
      bus.mem_en   = 1'b1;
      bus.mem_we   = 1'b1;
      bus.mem_addr = ptr_q;
      bus.mem_wdat = char_q;
    end else if (cpu_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_we   = bus.cpu_we;
      bus.mem_addr = bus.cpu_addr;
      bus.mem_wdat = bus.cpu_wdat;
    end
  end

  // Read data passes straight from the RAM in the cycle after the access.
  always_comb begin
    bus.ren_valid = ren_valid_q;
    bus.ren_dat   = ren_valid_q ? bus.mem_rdat : '0;
    bus.fill_busy = (fill_state_q == FILL_RUN);
    bus.cpu_ack   = (cpu_state_q == CPU_ACK);
    bus.cpu_rdat  = ((cpu_state_q == CPU_ACK) && !cpu_we_q) ? bus.mem_rdat : '0;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem_arr [0:4095];

  vram_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  vram_arbiter #(.ADDR_W(12), .DATA_W(8), .COLS(40), .ROWS(30)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port display RAM model.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdat;
      else            bus.mem_rdat <= mem_arr[bus.mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_poke(input logic [11:0] a, input logic [7:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdat = d;
    tick;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    bus.ren_req = 1'b1; bus.ren_addr = 12'h010;
    bus.fill_start = 1'b1; bus.fill_char = 8'h00;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h020; bus.cpu_wdat = 8'h00;
    bus.mem_rdat = 8'h00;
    repeat (3) tick;
    #1;
    checks++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h000) begin
      errors++; $display("FAIL reset_mem en=%b we=%b addr=%h exp 0 0 000", bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    checks++;
    if ({bus.ren_valid, bus.fill_busy, bus.cpu_ack} !== 3'b000 || bus.ren_dat !== 8'h00 || bus.cpu_rdat !== 8'h00) begin
      errors++; $display("FAIL reset_outs valid/busy/ack=%b%b%b ren_dat=%h cpu_rdat=%h exp 000 00 00",
                         bus.ren_valid, bus.fill_busy, bus.cpu_ack, bus.ren_dat, bus.cpu_rdat);
    end
    bus.ren_req = 1'b0; bus.fill_start = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    clr = 1'b0;
    tick;
    checks++;
    if (bus.fill_busy !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.ren_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release busy=%b ack=%b valid=%b exp 0 0 0", bus.fill_busy, bus.cpu_ack, bus.ren_valid);
    end
  endtask

  task automatic test_cpu_write_read;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h123; bus.cpu_wdat = 8'h5A;
    #1;
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h123 || bus.mem_wdat !== 8'h5A) begin
      errors++; $display("FAIL cpu_wr_grant en=%b we=%b addr=%h wdat=%h exp 1 1 123 5a", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdat);
    end
    tick;
    // Request stays up through the ack cycle and now asks for a read.
    bus.cpu_we = 1'b0;
    #1;
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== 8'h00) begin
      errors++; $display("FAIL cpu_wr_ack ack=%b rdat=%h exp 1 00", bus.cpu_ack, bus.cpu_rdat);
    end
    checks++;
    if (bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL cpu_ack_cycle_no_grant mem_en=%b exp 0", bus.mem_en);
    end
    tick;
    #1;
    checks++;
    if (bus.cpu_ack !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h123) begin
      errors++; $display("FAIL cpu_rd_grant ack=%b en=%b we=%b addr=%h exp 0 1 0 123", bus.cpu_ack, bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    tick;
    bus.cpu_req = 1'b0;
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== 8'h5A) begin
      errors++; $display("FAIL cpu_rd_ack ack=%b rdat=%h exp 1 5a", bus.cpu_ack, bus.cpu_rdat);
    end
    tick;
  endtask

  task automatic test_ren_read;
    cpu_poke(12'h04B, 8'h41);
    bus.ren_req = 1'b1; bus.ren_addr = 12'h04B;
    #1;
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h04B) begin
      errors++; $display("FAIL ren_grant en=%b we=%b addr=%h exp 1 0 04b", bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    tick;
    bus.ren_req = 1'b0;
    checks++;
    if (bus.ren_valid !== 1'b1 || bus.ren_dat !== 8'h41) begin
      errors++; $display("FAIL ren_data valid=%b dat=%h exp 1 41", bus.ren_valid, bus.ren_dat);
    end
    tick;
    checks++;
    if (bus.ren_valid !== 1'b0) begin
      errors++; $display("FAIL ren_valid_pulse valid=%b exp 0", bus.ren_valid);
    end
  endtask

  task automatic test_collision;
    bus.ren_req = 1'b1; bus.ren_addr = 12'h04B;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h123;
    #1;
    checks++;
    if (bus.mem_addr !== 12'h04B || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL coll_ren_first addr=%h we=%b exp 04b 0", bus.mem_addr, bus.mem_we);
    end
    tick;
    bus.ren_req = 1'b0;
    #1;
    checks++;
    if (bus.ren_valid !== 1'b1 || bus.ren_dat !== 8'h41 || bus.cpu_ack !== 1'b0 || bus.mem_addr !== 12'h123) begin
      errors++; $display("FAIL coll_second valid=%b dat=%h ack=%b addr=%h exp 1 41 0 123",
                         bus.ren_valid, bus.ren_dat, bus.cpu_ack, bus.mem_addr);
    end
    tick;
    bus.cpu_req = 1'b0;
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== 8'h5A) begin
      errors++; $display("FAIL coll_cpu_ack ack=%b rdat=%h exp 1 5a", bus.cpu_ack, bus.cpu_rdat);
    end
    tick;
  endtask

  task automatic test_fill;
    int cnt;
    int bad;
    cpu_poke(12'h7FF, 8'h99);
    cpu_poke(12'h4B0, 8'h77);
    bus.fill_start = 1'b1; bus.fill_char = 8'h20;
    #1;
    checks++;
    if (bus.fill_busy !== 1'b0 || bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL fill_start_cycle busy=%b en=%b exp 0 0", bus.fill_busy, bus.mem_en);
    end
    tick;
    bus.fill_start = 1'b0; bus.fill_char = 8'h00;
    cnt = 0;
    while (bus.fill_busy === 1'b1 && cnt < 5000) begin
      tick;
      cnt++;
    end
    checks++;
    if (cnt !== 1200) begin
      errors++; $display("FAIL fill_length cycles=%0d exp 1200", cnt);
    end
    bad = 0;
    for (int a = 0; a < 1200; a++) if (mem_arr[a] !== 8'h20) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL fill_contents bad_locations=%0d exp 0", bad);
    end
    checks++;
    if (mem_arr[1200] !== 8'h77) begin
      errors++; $display("FAIL fill_past_end mem[4b0]=%h exp 77", mem_arr[1200]);
    end
  endtask

  task automatic test_fill_with_ren;
    int cnt;
    int nren;
    int miss;
    int bad;
    logic was_req;
    bus.fill_start = 1'b1; bus.fill_char = 8'h2E;
    tick;
    bus.fill_start = 1'b0;
    cnt = 0; nren = 0; miss = 0;
    while (bus.fill_busy === 1'b1 && cnt < 5000) begin
      was_req = (cnt % 8 == 0);
      bus.ren_req = was_req; bus.ren_addr = 12'h7FF;
      if (was_req) nren++;
      tick;
      cnt++;
      if (was_req && (bus.ren_valid !== 1'b1 || bus.ren_dat !== 8'h99)) miss++;
    end
    bus.ren_req = 1'b0;
    checks++;
    if (cnt !== 1200 + nren) begin
      errors++; $display("FAIL fill_ren_length cycles=%0d exp %0d", cnt, 1200 + nren);
    end
    checks++;
    if (miss !== 0) begin
      errors++; $display("FAIL fill_ren_valid missed=%0d exp 0", miss);
    end
    bad = 0;
    for (int a = 0; a < 1200; a++) if (mem_arr[a] !== 8'h2E) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL fill_ren_contents bad_locations=%0d exp 0", bad);
    end
  endtask

  task automatic test_cpu_vs_fill;
    int cnt;
    int early;
    bus.fill_start = 1'b1; bus.fill_char = 8'h55;
    tick;
    bus.fill_start = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h7FF;
    cnt = 0; early = 0;
    while (bus.fill_busy === 1'b1 && cnt < 5000) begin
      if (bus.cpu_ack !== 1'b0) early++;
      tick;
      cnt++;
    end
    checks++;
    if (early !== 0 || cnt !== 1200) begin
      errors++; $display("FAIL cpu_fill_holdoff early_acks=%0d fill_cycles=%0d exp 0 1200", early, cnt);
    end
    #1;
    checks++;
    if (bus.cpu_ack !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 12'h7FF) begin
      errors++; $display("FAIL cpu_after_fill_grant ack=%b en=%b addr=%h exp 0 1 7ff", bus.cpu_ack, bus.mem_en, bus.mem_addr);
    end
    tick;
    bus.cpu_req = 1'b0;
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== 8'h99) begin
      errors++; $display("FAIL cpu_after_fill_ack ack=%b rdat=%h exp 1 99", bus.cpu_ack, bus.cpu_rdat);
    end
    tick;
  endtask

  task automatic test_reset_mid_fill;
    int cnt;
    int bad;
    bus.fill_start = 1'b1; bus.fill_char = 8'hEE;
    tick;
    bus.fill_start = 1'b0;
    cnt = 0;
    while (bus.fill_busy === 1'b1 && cnt < 5000) begin tick; cnt++; end
    checks++;
    if (cnt !== 1200) begin
      errors++; $display("FAIL prefill_length cycles=%0d exp 1200", cnt);
    end
    bus.fill_start = 1'b1; bus.fill_char = 8'h3C;
    tick;
    bus.fill_start = 1'b0;
    repeat (500) tick;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'd500) begin
      errors++; $display("FAIL mid_fill_ptr we=%b addr=%0d exp 1 500", bus.mem_we, bus.mem_addr);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL clr_blocks_mem en=%b exp 0", bus.mem_en);
    end
    tick;
    clr = 1'b0;
    checks++;
    if (bus.fill_busy !== 1'b0) begin
      errors++; $display("FAIL clr_abort busy=%b exp 0", bus.fill_busy);
    end
    bad = 0;
    for (int a = 0; a < 500; a++) if (mem_arr[a] !== 8'h3C) bad++;
    checks++;
    if (bad !== 0 || mem_arr[500] !== 8'hEE || mem_arr[501] !== 8'hEE) begin
      errors++; $display("FAIL clr_partial bad_low=%0d mem500=%h mem501=%h exp 0 ee ee", bad, mem_arr[500], mem_arr[501]);
    end
    bus.fill_start = 1'b1; bus.fill_char = 8'h11;
    tick;
    bus.fill_start = 1'b0;
    #1;
    checks++;
    if (bus.fill_busy !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h000 || bus.mem_wdat !== 8'h11) begin
      errors++; $display("FAIL refill_restart busy=%b we=%b addr=%h wdat=%h exp 1 1 000 11",
                         bus.fill_busy, bus.mem_we, bus.mem_addr, bus.mem_wdat);
    end
    cnt = 0;
    while (bus.fill_busy === 1'b1 && cnt < 5000) begin tick; cnt++; end
    bad = 0;
    for (int a = 0; a < 1200; a++) if (mem_arr[a] !== 8'h11) bad++;
    checks++;
    if (cnt !== 1200 || bad !== 0) begin
      errors++; $display("FAIL refill_complete cycles=%0d bad_locations=%0d exp 1200 0", cnt, bad);
    end
  endtask

  initial begin
    test_reset;
    test_cpu_write_read;
    test_ren_read;
    test_collision;
    test_fill;
    test_fill_with_ren;
    test_cpu_vs_fill;
    test_reset_mid_fill;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port text display memory between three requesters: the text renderer's character fetch, a screen-fill engine, and the CPU bus. The renderer has absolute priority so that pixel output is never stalled. The fill engine clears or fills the screen after a one-cycle command. The CPU gets a request/acknowledge handshake that tolerates arbitrary wait cycles. The block sits between the GPU text pipeline and the display RAM and drives the RAM's enable, write-enable, address and data pins.

## Interface
- ADDR_W, 12, display memory address width
- DATA_W, 8, character code width
- COLS, 40, text columns
- ROWS, 30, text rows; COLS*ROWS must be ≤ 2^ADDR_W

- clk  in  1  system clock; all logic on rising edge
- clr  in  1  reset, synchronous, active-high
- ren_req  in  1  renderer fetch request, single-cycle, never held
- ren_addr  in  ADDR_W  renderer character address
- ren_valid  out  1  renderer read data valid
- ren_dat  out  DATA_W  renderer read data
- fill_start  in  1  fill command pulse
- fill_char  in  DATA_W  fill character, sampled with fill_start
- fill_busy  out  1  fill in progress
- cpu_req  in  1  CPU access request, held until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdat  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdat  out  DATA_W  CPU read data, valid with cpu_ack
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdat  out  DATA_W  RAM write data
- mem_rdat  in  DATA_W  RAM read data, one cycle after mem_en with mem_we=0

## Operation
- The grant is decided combinationally each cycle. Priority: renderer > fill > CPU.
- The mem_* outputs are a combinational mux of the granted requester. With no grant, all mem_* outputs are 0.
- Renderer grant:
  - mem_en=1, mem_we=0, mem_addr=ren_addr.
  - The next cycle, ren_valid=1 and ren_dat=mem_rdat.
- Fill engine, states IDLE and FILL:
  - In IDLE, fill_start=1 captures fill_char, sets ptr=0 and moves to FILL.
  - In FILL, every cycle without ren_req writes: mem_we=1, mem_addr=ptr, mem_wdat=captured char; then ptr increments.
  - After the write at ptr = COLS*ROWS-1, the engine returns to IDLE.
  - fill_busy=1 exactly while in FILL.
  - fill_start while in FILL is ignored.
- CPU handshake, states IDLE, WAIT_ACK:
  - A CPU grant occurs when cpu_req=1, ren_req=0, fill is IDLE (including the cycle fill_start is sampled, which wins), and the CPU port is not in its ack cycle.
  - On grant: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdat=cpu_wdat.
  - The next cycle, cpu_ack=1. For reads, cpu_rdat=mem_rdat; for writes, cpu_rdat=0.
  - cpu_req seen during the ack cycle is not granted. Maximum throughput is one CPU access per 2 cycles.
  - CPU requests are held off for the entire fill.
- Address width rules:
  - ptr is ADDR_W bits and compares against the constant COLS*ROWS-1.
  - No address wrap or range check is applied to ren_addr or cpu_addr.

## Timing
- Reset:
  - Reset value of every registered output is 0: ren_valid, ren_dat, fill_busy, cpu_ack, cpu_rdat.
  - The fill FSM goes to IDLE with ptr=0; the CPU FSM goes to IDLE.
  - The mem_* outputs are 0 during clr.
  - clr mid-fill aborts the fill; locations already written stay written.
  - clr in the CPU grant cycle suppresses the ack.
- Latency:
  - Renderer read: 1 cycle, fixed, never stalled.
  - CPU: 1 cycle after grant; the wait before grant is unbounded while ren_req or fill is active.
- Fill duration: COLS*ROWS cycles plus one cycle per ren_req cycle during the fill. fill_busy rises the cycle after fill_start.
- Simultaneous events:
  - ren_req with a pending fill write: the fill write is deferred and ptr is held.
  - ren_req with cpu_req: the CPU waits and its ack is delayed by one cycle per collision.

## Test plan
- Renderer read: preload addr 0x04B=0x41. Drive ren_req, ren_addr=0x04B -> mem_en=1, mem_we=0 the same cycle; ren_valid=1, ren_dat=0x41 the next cycle.
- CPU write then read:
  - cpu_we=1, addr 0x123, wdat 0x5A -> cpu_ack 1 cycle after req.
  - Read of 0x123 -> cpu_ack with cpu_rdat=0x5A, two cycles after the read req.
- Collision: ren_req and cpu_req asserted in the same cycle -> renderer is served, cpu_ack arrives 2 cycles after req, and ren_valid is unaffected.
- Fill:
  - fill_start with fill_char=0x20 -> fill_busy high 1200 cycles; all 1200 locations read back 0x20.
  - With ren_req every 8th cycle, fill_busy lasts 1200 + number of ren_req cycles; ren_valid is never missed.
- CPU vs fill: cpu_req asserted during a fill -> no cpu_ack until the cycle after fill_busy falls plus 1.
- Reset mid-fill: clr at ptr=500 -> fill_busy=0 the next cycle; locations 0..499 hold fill_char and 500 is unchanged. A subsequent fill_start restarts from 0.
